// File: rtl/matrix_mult_seq.sv
// ============================================================================
//  Module   : matrix_mult_seq
//  Purpose  : Sequential N x N signed matrix multiplier. Computes C = A*B,
//             or C = A*B^T when mode_bt is latched high with start. A single
//             multiply-accumulate unit is time-shared over all N^3 products.
//  Ports    : clk, rst_n (async, active-low)
//             start / mode_bt        - job request and transpose select
//             in_valid/in_ready/in_data    - operand stream, A then B, row-major
//             out_valid/out_ready/out_data - result stream, row-major
//             out_last               - marks C[N-1][N-1]
//             busy                   - high outside IDLE
//             done                   - one-cycle pulse after last result
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_mult_seq #(
    parameter  int N  = 8,
    parameter  int DW = 8,
    localparam int OW = 2*DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode_bt,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int NN = N*N;
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(NN);
    localparam int CW = $clog2(2*NN);
    localparam int EW = OW - 2*DW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operand and result storage (not reset)
    logic signed [DW-1:0]   r_a [NN];
    logic signed [DW-1:0]   r_b [NN];
    logic signed [OW-1:0]   r_c [NN];

    logic                   r_mode;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_i;
    logic [IW-1:0]          r_j;
    logic [IW-1:0]          r_k;
    logic                   r_issue_done;

    // Product pipeline stage: the extra cycle this adds is the one cycle
    // between the final product issue and the first valid output.
    logic                   r_pv;
    logic                   r_pk0;
    logic                   r_plast;
    logic [AW-1:0]          r_pidx;
    logic signed [2*DW-1:0] r_prod;
    logic signed [OW-1:0]   r_acc;

    logic [AW-1:0]          r_oidx;
    logic                   r_done;

    logic                   w_in_fire;
    logic                   w_load_last;
    logic                   w_issue;
    logic                   w_issue_last;
    logic                   w_drain_last;
    logic                   w_out_fire;
    logic                   w_out_last_fire;
    logic [AW-1:0]          w_a_idx;
    logic [AW-1:0]          w_b_idx;
    logic [AW-1:0]          w_c_idx;
    logic signed [2*DW-1:0] w_prod;
    logic signed [OW-1:0]   w_prod_ext;
    logic signed [OW-1:0]   w_acc_next;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_in_fire       = (r_state == S_LOAD) && in_valid;
    assign w_load_last     = w_in_fire && (r_cnt == CW'(2*NN-1));
    assign w_issue         = (r_state == S_COMPUTE) && !r_issue_done;
    assign w_issue_last    = w_issue && (r_i == IW'(N-1)) && (r_j == IW'(N-1))
                             && (r_k == IW'(N-1));
    assign w_drain_last    = r_pv && r_plast && (r_pidx == AW'(NN-1));
    assign w_out_fire      = (r_state == S_OUTPUT) && out_ready;
    assign w_out_last_fire = w_out_fire && (r_oidx == AW'(NN-1));

    // ------------------------------------------------------------------
    // Datapath: operand addressing, product, accumulate
    // ------------------------------------------------------------------
    assign w_a_idx    = AW'(r_i * N + r_k);
    // Transpose mode reads B[j][k] instead of B[k][j]
    assign w_b_idx    = r_mode ? AW'(r_j * N + r_k) : AW'(r_k * N + r_j);
    assign w_c_idx    = AW'(r_i * N + r_j);
    assign w_prod     = r_a[w_a_idx] * r_b[w_b_idx];
    assign w_prod_ext = {{EW{r_prod[2*DW-1]}}, r_prod};
    assign w_acc_next = (r_pk0 ? '0 : r_acc) + w_prod_ext;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start)           w_next = S_LOAD;
            S_LOAD:    if (w_load_last)     w_next = S_COMPUTE;
            S_COMPUTE: if (w_drain_last)    w_next = S_OUTPUT;
            S_OUTPUT:  if (w_out_last_fire) w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and pipeline control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= 1'b0;
            r_cnt        <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_issue_done <= 1'b0;
            r_pv         <= 1'b0;
            r_pk0        <= 1'b0;
            r_plast      <= 1'b0;
            r_pidx       <= '0;
            r_acc        <= '0;
            r_oidx       <= '0;
            r_done       <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_mode <= mode_bt;
            end

            if (w_in_fire) begin
                r_cnt <= w_load_last ? '0 : r_cnt + CW'(1);
            end

            if (r_state == S_LOAD) begin
                r_issue_done <= 1'b0;
            end

            // i/j/k walk row-major over C with k innermost; all three wrap
            // back to zero after the final issue so the next job starts clean.
            if (w_issue) begin
                if (r_k == IW'(N-1)) begin
                    r_k <= '0;
                    if (r_j == IW'(N-1)) begin
                        r_j <= '0;
                        r_i <= (r_i == IW'(N-1)) ? '0 : r_i + IW'(1);
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end else begin
                    r_k <= r_k + IW'(1);
                end
                if (w_issue_last) begin
                    r_issue_done <= 1'b1;
                end
            end

            r_pv    <= w_issue;
            r_pk0   <= (r_k == '0);
            r_plast <= (r_k == IW'(N-1));
            r_pidx  <= w_c_idx;

            if (r_pv) begin
                r_acc <= w_acc_next;
            end

            if (w_out_fire) begin
                r_oidx <= w_out_last_fire ? '0 : r_oidx + AW'(1);
            end

            r_done <= w_out_last_fire;
        end
    end

    // ------------------------------------------------------------------
    // Storage writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            if (r_cnt < CW'(NN)) begin
                r_a[AW'(r_cnt)] <= in_data;
            end else begin
                r_b[AW'(r_cnt - CW'(NN))] <= in_data;
            end
        end
        r_prod <= w_prod;
        if (r_pv && r_plast) begin
            r_c[r_pidx] <= w_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_OUTPUT);
    assign out_data  = (r_state == S_OUTPUT) ? r_c[r_oidx] : '0;
    assign out_last  = (r_state == S_OUTPUT) && (r_oidx == AW'(NN-1));
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

`default_nettype wire

// File: doc/matrix_mult_seq.md
# matrix_mult_seq

Sequential, parametrised N×N signed matrix multiplier for the image-compression datapath. It computes C = A·B, or C = A·Bᵀ in transpose mode, which lets the DCT stage form T·X·Tᵀ as two passes. The block replaces the fixed 8×8 combinational multiplier. Operands arrive as one element stream and results leave as another, each with valid/ready handshakes. A single MAC is time-shared across all output elements.

## Interface
Parameters:
- N, 8, matrix dimension (N ≥ 2).
- DW, 8, operand width, signed two's complement.
- OW, 2*DW+$clog2(N), result width, derived and not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a job; honoured only in IDLE.
- mode_bt  in  1  sampled with start: 1 selects C = A·Bᵀ, 0 selects C = A·B.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts an operand beat.
- in_data  in  DW  operand element, row-major.
- out_valid  out  1  result beat valid.
- out_ready  in  1  sink accepts a result beat.
- out_data  out  OW  result element, row-major, sign-extended full precision.
- out_last  out  1  high with element C[N-1][N-1].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final result handshake.

## Operation
States: IDLE, LOAD, COMPUTE, OUTPUT.

- **IDLE**
  - in_ready=0, out_valid=0.
  - start=1 latches mode_bt and moves to LOAD.
- **LOAD**
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - Accepted beats 0..N²-1 fill A[i][j] in row-major order: index = i*N+j.
  - Accepted beats N²..2N²-1 fill B[i][j] in the same order.
  - Gaps in in_valid are allowed and the beat counter holds during them.
  - The final B beat moves to COMPUTE.
- **COMPUTE**
  - in_ready=0. Elements are processed in order (i,j) = (0,0),(0,1)…(N-1,N-1). Each element takes k = 0..N-1, one product per cycle.
  - acc = (k==0 ? 0 : acc) + A[i][k]*Bsel, where Bsel = B[k][j] (mode 0) or B[j][k] (mode 1).
  - The final acc of each element is written to the C buffer.
  - After N³ cycles the state moves to OUTPUT.
- **OUTPUT**
  - out_valid=1 and out_data=C[idx], starting at idx=0.
  - idx advances on out_valid && out_ready.
  - out_last=1 when idx=N²-1.
  - The handshake on the last element pulses done, returns to IDLE and drops out_valid in the same edge.
- **Arithmetic**
  - Operands are sign-extended. The product is 2DW bits and the accumulator is OW bits.
  - No rounding, no saturation. The OW width guarantees no overflow for any operands.
- **start outside IDLE** is ignored, including during OUTPUT. mode_bt is only sampled at start.
- **Storage**
  - A, B and C storage is not reset. Only control state and outputs are.
  - Storage may be register arrays or inferred RAM, provided the timing below holds.

## Timing
- **Reset values:** state=IDLE, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, and all counters 0.
- **Reset mid-operation:** the block returns to IDLE immediately. Any partial job is discarded and the next start begins a fresh LOAD.
- **start:** sampled at edge t0. in_ready and busy are 1 from t0+1.
- **Compute latency:** let tB be the edge that accepts the final B beat.
  - COMPUTE occupies edges tB+1 … tB+N³.
  - out_valid is first high in the cycle after edge tB+N³, i.e. it is registered high at tB+N³+1.
  - Any internal multiplier pipelining must be absorbed inside the N³ window.
- **Output under backpressure:** while out_valid && !out_ready, out_data and out_last hold stable.
- **done:** high for exactly one cycle, following the edge of the final output handshake. busy=0 in that same cycle.
- **Minimum job length (N=8), with no stalls:**
  - 1 cycle for start.
  - 128 cycles for load.
  - 512 cycles for compute.
  - 64 cycles for output.

## Test plan
- **Identity, mode 0:** N=8, A=I, B[i][j]=i*8+j-32. The output must equal B element-for-element; out_last is high only on beat 63 and done pulses once.
- **Extremes:** A and B all -128. Every out_data must be +131072 (OW=19), with no overflow. Then set A all -128 and B all 127: every out_data must be -130048.
- **Transpose mode:** mode_bt=1, A=I, B[i][j]=i*8+j. The output must be C[i][j]=j*8+i.
- **Handshake stress:** random gaps on in_valid and a random out_ready duty cycle of about 30%. Results must match the golden model, out_data must hold whenever stalled, and the first out_valid must come exactly 513 cycles after the last B accept.
- **Reset and stray start:**
  - Assert rst_n=0 at COMPUTE cycle 200. All outputs must read their reset values within the same cycle.
  - Run a fresh job afterwards; it must be correct.
  - Pulse start during LOAD and during OUTPUT; both must be ignored.
- **Parameter sweep:** N=4 with DW=12 (OW=26), and N=2 with DW=8, using random signed matrices. Results must be bit-exact against the golden model.
